// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Purpose:
//   Instruction fetch for the pipeline. Holds the program counter, chooses the
//   next fetch address, drives a synchronous (1-cycle latency) instruction ROM
//   and owns the IF/ID pipeline register that feeds the decode stage. It obeys
//   the stall (nop) and flush/redirect controls from the hazard unit with the
//   priority flush > stall > advance. It stops fetching on a HALT opcode and
//   keeps saturating debug counters of applied stalls and flushes.
//
// Ports:
//   clk            in   1        clock, rising edge
//   rst_n          in   1        asynchronous active-low reset
//   nop            in   2        stall request, active when non-zero
//   flush          in   2        flush/redirect request, active when non-zero
//   branch_target  in   PC_W     redirect address, used when flush is active
//   imem_addr      out  PC_W     ROM address (combinational, = next PC)
//   imem_rdata     in   INSTR_W  ROM data for the address of the last cycle
//   instr_decode   out  INSTR_W  IF/ID instruction (0 for a bubble)
//   pc_decode      out  PC_W     IF/ID PC of instr_decode
//   valid_decode   out  1        IF/ID holds a real instruction
//   halted         out  1        fetch is halted
//   stall_count    out  CNT_W    applied-stall cycles, saturating
//   flush_count    out  CNT_W    applied-flush cycles, saturating
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int              PC_W     = 16,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 1,
    parameter int              OPC_LSB  = 27,
    parameter logic [4:0]      HALT_OPC = 5'b11111,
    parameter int              CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         nop,
    input  logic [1:0]         flush,
    input  logic [PC_W-1:0]    branch_target,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_decode,
    output logic [PC_W-1:0]    pc_decode,
    output logic               valid_decode,
    output logic               halted,
    output logic [CNT_W-1:0]   stall_count,
    output logic [CNT_W-1:0]   flush_count
);

    localparam logic [PC_W-1:0]  C_PC_STEP = PC_W'(PC_STEP);
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // ---------------------------------------------------------------------
    // Registers and their next-state values
    // ---------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_next;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    w_pc_next;
    logic [INSTR_W-1:0] r_ifid_instr;
    logic [INSTR_W-1:0] w_ifid_instr_next;
    logic [PC_W-1:0]    r_ifid_pc;
    logic [PC_W-1:0]    w_ifid_pc_next;
    logic               r_ifid_valid;
    logic               w_ifid_valid_next;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;

    // ---------------------------------------------------------------------
    // Decoded controls
    // ---------------------------------------------------------------------
    logic               w_stall_req;
    logic               w_flush_req;
    logic [4:0]         w_opcode;
    logic               w_is_halt;
    logic [PC_W-1:0]    w_pc_plus;
    logic               w_stall_inc;
    logic               w_flush_inc;

    assign w_stall_req = |nop;
    assign w_flush_req = |flush;
    assign w_opcode    = imem_rdata[OPC_LSB +: 5];
    assign w_is_halt   = (w_opcode == HALT_OPC);
    // Natural modulo-2^PC_W wrap of the increment.
    assign w_pc_plus   = r_pc + C_PC_STEP;

    // ---------------------------------------------------------------------
    // Next-state / next-PC / IF/ID logic
    // Default is "hold everything"; each branch overrides what it changes.
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_ifid_instr_next = r_ifid_instr;
        w_ifid_pc_next    = r_ifid_pc;
        w_ifid_valid_next = r_ifid_valid;
        w_stall_inc       = 1'b0;
        w_flush_inc       = 1'b0;

        case (r_state)
            ST_BOOT: begin
                // The ROM has not yet produced data for RESET_PC, so decode
                // gets a bubble while the first read is issued. Hazard
                // controls are meaningless here and are ignored.
                w_pc_next         = RESET_PC;
                w_ifid_instr_next = '0;
                w_ifid_pc_next    = '0;
                w_ifid_valid_next = 1'b0;
                w_state_next      = ST_RUN;
            end

            ST_RUN: begin
                if (w_flush_req) begin
                    w_pc_next         = branch_target;
                    w_ifid_instr_next = '0;
                    w_ifid_pc_next    = '0;
                    w_ifid_valid_next = 1'b0;
                    w_flush_inc       = 1'b1;
                end else if (w_stall_req) begin
                    // PC held: the ROM re-reads the same word so imem_rdata
                    // is still correct when the stall releases.
                    w_stall_inc = 1'b1;
                end else begin
                    w_ifid_instr_next = imem_rdata;
                    w_ifid_pc_next    = r_pc;
                    w_ifid_valid_next = 1'b1;
                    if (w_is_halt) begin
                        // The halt itself goes to decode; fetch freezes here.
                        w_state_next = ST_HALT;
                    end else begin
                        w_pc_next = w_pc_plus;
                    end
                end
            end

            ST_HALT: begin
                if (w_flush_req) begin
                    // Halt was on a mispredicted path: resume at the target.
                    w_pc_next         = branch_target;
                    w_ifid_instr_next = '0;
                    w_ifid_pc_next    = '0;
                    w_ifid_valid_next = 1'b0;
                    w_flush_inc       = 1'b1;
                    w_state_next      = ST_RUN;
                end else if (w_stall_req) begin
                    w_stall_inc = 1'b1;
                end else begin
                    w_ifid_instr_next = '0;
                    w_ifid_pc_next    = '0;
                    w_ifid_valid_next = 1'b0;
                end
            end

            default: begin
                w_state_next      = ST_BOOT;
                w_pc_next         = RESET_PC;
                w_ifid_instr_next = '0;
                w_ifid_pc_next    = '0;
                w_ifid_valid_next = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State, PC and IF/ID registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_BOOT;
            r_pc         <= RESET_PC;
            r_ifid_instr <= '0;
            r_ifid_pc    <= '0;
            r_ifid_valid <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_ifid_instr <= w_ifid_instr_next;
            r_ifid_pc    <= w_ifid_pc_next;
            r_ifid_valid <= w_ifid_valid_next;
        end
    end

    // ---------------------------------------------------------------------
    // Saturating debug counters
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall_inc && (r_stall_cnt != C_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush_cnt <= '0;
        end else if (w_flush_inc && (r_flush_cnt != C_CNT_MAX)) begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    // The ROM registers its address, so presenting the next PC now makes the
    // data for pc_q available in the cycle after it becomes current. Reset is
    // folded in so the address is defined while rst_n is low.
    assign imem_addr    = rst_n ? w_pc_next : RESET_PC;
    assign instr_decode = r_ifid_instr;
    assign pc_decode    = r_ifid_pc;
    assign valid_decode = r_ifid_valid;
    assign halted       = (r_state == ST_HALT);
    assign stall_count  = r_stall_cnt;
    assign flush_count  = r_flush_cnt;

endmodule
